uu_rd_scoreboard: RTL and testbench
===================================

// Module: uu_rd_scoreboard
// PURPOSE
//  Tracks destination register (rd) of every in-flight multi-cycle unit (int div, FP units) from issue until the
//  result reaches MEM. Feeds clear_units_decoder: rd_used, reg_write_unit, FP_reg_write_unit, all_uu_rd_busy.
//  Consumes its clear_rd to kill superseded results. Gives decode RAW/WAW/structural hazard flags.
// PARAMETERS
//  num_rds        9  tracked units; index 0 = integer divider, 1..num_rds-1 = FP units
//  rd_addr_width  5  rd/rs address bits
// PORTS
//  clk               in   1              core clock
//  reset             in   1              asynchronous, active-high reset
//  issue_unit        in   num_rds        one-hot: instruction enters unit i this cycle (all-zero = none)
//  issue_rd          in   rd_addr_width  rd of issuing instruction
//  issue_reg_write   in   1              issuing rd is integer
//  issue_fp_write    in   1              issuing rd is FP
//  unit_done         in   num_rds        unit i result reaches MEM this cycle
//  clear_rd          in   num_rds        kill unit i result (from clear_units_decoder)
//  dec_rs1/rs2/rs3   in   rd_addr_width  source regs of instruction in decode
//  dec_rs1_fp/rs2_fp in   1              rs1/rs2 read FP file (rs3 is always FP)
//  is_R4_instruction in   1              rs3 valid
//  dec_rd            in   rd_addr_width  rd of instruction in decode
//  dec_reg_write     in   1              decode rd integer
//  dec_fp_write      in   1              decode rd FP
//  rd_used           out  rd_addr_width x num_rds  stored rd per unit
//  reg_write_unit    out  num_rds        stored rd is integer
//  FP_reg_write_unit out  num_rds        stored rd is FP
//  all_uu_rd_busy    out  num_rds        entry in BUSY (result pending, will write)
//  unit_occupied     out  num_rds        entry not IDLE (BUSY or KILLED)
//  raw_stall         out  1              decode source matches a BUSY rd
//  waw_hit           out  1              decode rd matches a BUSY rd
//  error_issue       out  1              issue to occupied unit without same-cycle done (sticky)
// BEHAVIOUR
//  Reset: every entry IDLE, rd_used=0, type bits 0, all outputs 0, error_issue 0. Reset mid-operation aborts all.
//  Per-entry FSM (state, rd, int, fp registers):
//   IDLE   -issue_unit[i]-> BUSY; latch issue_rd/types.
//   BUSY   -unit_done[i]-> IDLE; -clear_rd[i] (no done)-> KILLED (rd kept, busy drops, still occupied).
//   KILLED -unit_done[i]-> IDLE (result discarded downstream by all_uu_rd_busy=0).
//   Priority same cycle: issue > done > clear. done+issue in any state -> BUSY with new rd (pipelined back-to-back).
//   clear+done in BUSY -> IDLE. Issue to BUSY/KILLED with no done: ignored, state unchanged, error_issue set.
//   Issue with neither write flag or int rd=x0: entry goes BUSY but busy flag forced 0 (occupancy only).
//  Latency: issue in cycle N -> all_uu_rd_busy/rd_used visible N+1. Outputs driven directly from registers.
//  Hazards (combinational from registered state, entries with unit_done[i] this cycle excluded = MEM bypass):
//   match = BUSY && rd_used==src && file equal; int x0 never matches; FP f0 matches.
//   raw_stall = match on rs1 | rs2 | (rs3 & is_R4_instruction).
//   waw_hit   = match on dec_rd with dec_reg_write/dec_fp_write selecting file.
//  clear_rd on IDLE/KILLED entry: no effect. unit_done on IDLE entry: no effect.
// STRUCTURE
//  Package raw_waw_pkg: typedef enum logic[1:0] {UU_IDLE, UU_BUSY, UU_KILLED} uu_state_t; UU_DIV_IDX=0;
//   RD_ADDR_WIDTH=5; NUM_UU=9 defaults shared with clear_units_decoder.
//  Sub-module uu_rd_entry: one FSM + rd/type regs + per-source match outputs; generate loop num_rds instances;
//   top ORs matches and flags error_issue.
// TESTING
//  1 issue_unit=1<<0, rd=x5 int; cycle+1 rd_used[0]=5, busy[0]=1; dec_rs1=5 int -> raw_stall=1; rs1=5 FP -> 0.
//  2 FP unit 3 rd=f7 busy; unit_done[3] same cycle as dec_rs2=f7 fp -> raw_stall=0; next cycle state IDLE.
//  3 unit 2 rd=f4 BUSY, clear_rd[2] -> KILLED: busy[2]=0, occupied[2]=1, waw_hit=0 for f4; done -> IDLE.
//  4 unit 0 BUSY rd=x9, issue_unit[0] without done -> ignored, rd stays 9, error_issue=1; with done -> rd updates.
//  5 issue int rd=x0 -> busy[0]=0, occupied[0]=1; dec_rs1=x0 -> raw_stall=0; is_R4=0 with rs3 match -> 0.
//  6 reset asserted while three units BUSY -> all outputs 0 asynchronously, stays IDLE after release.

Source files
------------

// File: rtl/uu_rd_scoreboard_pkg.sv
// uu_rd_scoreboard_pkg: shared entry states and default sizes for the in-flight rd scoreboard
package raw_waw_pkg;
    typedef enum logic [1:0] {UU_IDLE, UU_BUSY, UU_KILLED} uu_state_t;
    localparam int UU_DIV_IDX = 0;
    localparam int RD_ADDR_WIDTH = 5;
    localparam int NUM_UU = 9;
endpackage

// File: rtl/uu_rd_scoreboard_if.sv
// uu_rd_scoreboard_if: issue/retire/decode bundle of the multi-cycle unit rd scoreboard
// master drives issue, done, clear and decode operands; slave returns stored rd, flags and hazards
interface uu_rd_scoreboard_if
    import raw_waw_pkg::*;
#(
    parameter int num_rds       = NUM_UU,
    parameter int rd_addr_width = RD_ADDR_WIDTH
);
    logic [num_rds-1:0]                    issue_unit;
    logic [rd_addr_width-1:0]              issue_rd;
    logic                                  issue_reg_write;
    logic                                  issue_fp_write;
    logic [num_rds-1:0]                    unit_done;
    logic [num_rds-1:0]                    clear_rd;
    logic [rd_addr_width-1:0]              dec_rs1;
    logic [rd_addr_width-1:0]              dec_rs2;
    logic [rd_addr_width-1:0]              dec_rs3;
    logic                                  dec_rs1_fp;
    logic                                  dec_rs2_fp;
    logic                                  is_R4_instruction;
    logic [rd_addr_width-1:0]              dec_rd;
    logic                                  dec_reg_write;
    logic                                  dec_fp_write;
    logic [num_rds-1:0][rd_addr_width-1:0] rd_used;
    logic [num_rds-1:0]                    reg_write_unit;
    logic [num_rds-1:0]                    FP_reg_write_unit;
    logic [num_rds-1:0]                    all_uu_rd_busy;
    logic [num_rds-1:0]                    unit_occupied;
    logic                                  raw_stall;
    logic                                  waw_hit;
    logic                                  error_issue;
    modport master (
        output issue_unit, issue_rd, issue_reg_write, issue_fp_write, unit_done, clear_rd,
               dec_rs1, dec_rs2, dec_rs3, dec_rs1_fp, dec_rs2_fp, is_R4_instruction,
               dec_rd, dec_reg_write, dec_fp_write,
        input  rd_used, reg_write_unit, FP_reg_write_unit, all_uu_rd_busy, unit_occupied,
               raw_stall, waw_hit, error_issue
    );
    modport slave (
        input  issue_unit, issue_rd, issue_reg_write, issue_fp_write, unit_done, clear_rd,
               dec_rs1, dec_rs2, dec_rs3, dec_rs1_fp, dec_rs2_fp, is_R4_instruction,
               dec_rd, dec_reg_write, dec_fp_write,
        output rd_used, reg_write_unit, FP_reg_write_unit, all_uu_rd_busy, unit_occupied,
               raw_stall, waw_hit, error_issue
    );
endinterface

// File: rtl/uu_rd_scoreboard_entry.sv
// uu_rd_entry: one tracked unit - IDLE/BUSY/KILLED FSM, stored rd and file bits, per-source hazard matches
// in: issue/done/clear for this unit, issuing rd+types, decode sources and rd
// out: stored rd/types, busy, occupied, raw/waw match, illegal-issue pulse
module uu_rd_entry
    import raw_waw_pkg::*;
#(
    parameter int rd_addr_width = RD_ADDR_WIDTH
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_issue,
    input  logic [rd_addr_width-1:0] i_issue_rd,
    input  logic                     i_issue_int,
    input  logic                     i_issue_fp,
    input  logic                     i_done,
    input  logic                     i_clear,
    input  logic [rd_addr_width-1:0] i_rs1,
    input  logic [rd_addr_width-1:0] i_rs2,
    input  logic [rd_addr_width-1:0] i_rs3,
    input  logic                     i_rs1_fp,
    input  logic                     i_rs2_fp,
    input  logic                     i_r4,
    input  logic [rd_addr_width-1:0] i_rd,
    input  logic                     i_rd_int,
    input  logic                     i_rd_fp,
    output logic [rd_addr_width-1:0] o_rd,
    output logic                     o_int,
    output logic                     o_fp,
    output logic                     o_busy,
    output logic                     o_occupied,
    output logic                     o_raw,
    output logic                     o_waw,
    output logic                     o_err
);
    uu_state_t r_state, w_next;
    logic [rd_addr_width-1:0] r_rd;
    logic r_int, r_fp, r_live, w_load, w_pend;
    // a same-cycle done frees the unit, so issue is accepted back-to-back
    assign w_load = i_issue && (r_state == UU_IDLE || i_done);
    always_comb begin
        w_next = r_state;
        w_next = w_load ? UU_BUSY :
                 i_issue ? r_state :
                 i_done ? UU_IDLE :
                 (i_clear && r_state == UU_BUSY) ? UU_KILLED : r_state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= UU_IDLE;
            r_rd    <= '0;
            r_int   <= 1'b0;
            r_fp    <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_rd   <= i_issue_rd;
                r_int  <= i_issue_int;
                r_fp   <= i_issue_fp;
                // no architectural write (no file, or int x0): occupancy only
                r_live <= i_issue_fp || (i_issue_int && i_issue_rd != '0);
            end
        end
    end
    // result retiring this cycle is bypassed from MEM, so it no longer blocks decode
    assign w_pend = o_busy && !i_done;
    function automatic logic f_match(input logic [rd_addr_width-1:0] src, input logic src_fp);
        return w_pend && r_rd == src && (src_fp ? r_fp : (r_int && src != '0));
    endfunction
    assign o_rd       = r_rd;
    assign o_int      = r_int;
    assign o_fp       = r_fp;
    assign o_busy     = r_state == UU_BUSY && r_live;
    assign o_occupied = r_state != UU_IDLE;
    assign o_raw      = f_match(i_rs1, i_rs1_fp) || f_match(i_rs2, i_rs2_fp) || (i_r4 && f_match(i_rs3, 1'b1));
    assign o_waw      = (i_rd_int && f_match(i_rd, 1'b0)) || (i_rd_fp && f_match(i_rd, 1'b1));
    assign o_err      = i_issue && !w_load;
endmodule

// File: rtl/uu_rd_scoreboard.sv
// uu_rd_scoreboard: tracks rd of every in-flight multi-cycle unit and flags decode RAW/WAW hazards
// clk, reset (async active-high); bus (slave): issue/done/clear/decode in, rd_used/flags/hazards out
module uu_rd_scoreboard
    import raw_waw_pkg::*;
#(
    parameter int num_rds       = NUM_UU,
    parameter int rd_addr_width = RD_ADDR_WIDTH
)(
    input logic               clk,
    input logic               reset,
    uu_rd_scoreboard_if.slave bus
);
    logic [num_rds-1:0] w_raw, w_waw, w_err, w_int, w_fp, w_busy, w_occ;
    logic [num_rds-1:0][rd_addr_width-1:0] w_rd;
    logic r_error_issue;
    generate
        for (genvar g = 0; g < num_rds; g++) begin : g_entry
            uu_rd_entry #(.rd_addr_width(rd_addr_width)) u_entry (
                .clk        (clk),
                .reset      (reset),
                .i_issue    (bus.issue_unit[g]),
                .i_issue_rd (bus.issue_rd),
                .i_issue_int(bus.issue_reg_write),
                .i_issue_fp (bus.issue_fp_write),
                .i_done     (bus.unit_done[g]),
                .i_clear    (bus.clear_rd[g]),
                .i_rs1      (bus.dec_rs1),
                .i_rs2      (bus.dec_rs2),
                .i_rs3      (bus.dec_rs3),
                .i_rs1_fp   (bus.dec_rs1_fp),
                .i_rs2_fp   (bus.dec_rs2_fp),
                .i_r4       (bus.is_R4_instruction),
                .i_rd       (bus.dec_rd),
                .i_rd_int   (bus.dec_reg_write),
                .i_rd_fp    (bus.dec_fp_write),
                .o_rd       (w_rd[g]),
                .o_int      (w_int[g]),
                .o_fp       (w_fp[g]),
                .o_busy     (w_busy[g]),
                .o_occupied (w_occ[g]),
                .o_raw      (w_raw[g]),
                .o_waw      (w_waw[g]),
                .o_err      (w_err[g])
            );
        end
    endgenerate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_error_issue <= 1'b0;
        else if (|w_err) r_error_issue <= 1'b1;
    end
    assign bus.rd_used           = w_rd;
    assign bus.reg_write_unit    = w_int;
    assign bus.FP_reg_write_unit = w_fp;
    assign bus.all_uu_rd_busy    = w_busy;
    assign bus.unit_occupied     = w_occ;
    assign bus.raw_stall         = |w_raw;
    assign bus.waw_hit           = |w_waw;
    assign bus.error_issue       = r_error_issue;
endmodule

// File: tb/tb_uu_rd_scoreboard.sv
// tb_uu_rd_scoreboard: directed + random stimulus, reference model pushes expectations, monitor compares
module tb_uu_rd_scoreboard;
    localparam int N = 9;
    localparam int W = 5;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    uu_rd_scoreboard_if #(.num_rds(N), .rd_addr_width(W)) bus();
    uu_rd_scoreboard #(.num_rds(N), .rd_addr_width(W)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct packed {
        logic               raw;
        logic               waw;
        logic [N-1:0]       busy;
        logic [N-1:0]       occ;
        logic [N-1:0]       iw;
        logic [N-1:0]       fw;
        logic [N-1:0][W-1:0] rdu;
        logic               err;
    } exp_t;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    // model: 0 = nothing in flight, 1 = result pending, 2 = result killed but unit still working
    int         m_st[N];
    logic [W-1:0] m_rd[N];
    logic       m_int[N];
    logic       m_fp[N];
    logic       m_err;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic writes(input int i);
        return m_fp[i] || (m_int[i] && m_rd[i] != 0);
    endfunction
    function automatic logic hit(input int i, input logic [W-1:0] src, input logic sfp);
        if (m_st[i] != 1 || !writes(i) || bus.unit_done[i] || m_rd[i] != src) return 1'b0;
        return sfp ? m_fp[i] : (m_int[i] && src != 0);
    endfunction
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_rd[i] = '0; m_int[i] = 1'b0; m_fp[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask
    task automatic idle();
        bus.issue_unit = '0; bus.issue_rd = '0; bus.issue_reg_write = 0; bus.issue_fp_write = 0;
        bus.unit_done = '0; bus.clear_rd = '0;
        bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rs3 = '0; bus.dec_rs1_fp = 0; bus.dec_rs2_fp = 0;
        bus.is_R4_instruction = 0; bus.dec_rd = '0; bus.dec_reg_write = 0; bus.dec_fp_write = 0;
    endtask
    task automatic issue(input int u, input int rd, input logic iw, input logic fw);
        bus.issue_unit = '0;
        bus.issue_unit[u] = 1'b1;
        bus.issue_rd = rd[W-1:0];
        bus.issue_reg_write = iw;
        bus.issue_fp_write = fw;
    endtask
    // called at posedge+1 with inputs set: push expectation for this cycle, advance model at the edge
    task automatic step();
        exp_t e;
        if (reset) model_reset();
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.busy[i] = m_st[i] == 1 && writes(i);
            e.occ[i]  = m_st[i] != 0;
            e.iw[i]   = m_int[i];
            e.fw[i]   = m_fp[i];
            e.rdu[i]  = m_rd[i];
            e.raw |= hit(i, bus.dec_rs1, bus.dec_rs1_fp) || hit(i, bus.dec_rs2, bus.dec_rs2_fp) ||
                     (bus.is_R4_instruction && hit(i, bus.dec_rs3, 1'b1));
            e.waw |= (bus.dec_reg_write && hit(i, bus.dec_rd, 1'b0)) || (bus.dec_fp_write && hit(i, bus.dec_rd, 1'b1));
        end
        e.err = m_err;
        q.push_back(e);
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (bus.issue_unit[i]) begin
                    if (m_st[i] == 0 || bus.unit_done[i]) begin
                        m_st[i] = 1; m_rd[i] = bus.issue_rd;
                        m_int[i] = bus.issue_reg_write; m_fp[i] = bus.issue_fp_write;
                    end else m_err = 1'b1;
                end else if (bus.unit_done[i]) m_st[i] = 0;
                else if (bus.clear_rd[i] && m_st[i] == 1) m_st[i] = 2;
            end
        end
        #1;
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("raw_stall", bus.raw_stall, e.raw);
            chk("waw_hit", bus.waw_hit, e.waw);
            chk("all_uu_rd_busy", bus.all_uu_rd_busy, e.busy);
            chk("unit_occupied", bus.unit_occupied, e.occ);
            chk("reg_write_unit", bus.reg_write_unit, e.iw);
            chk("FP_reg_write_unit", bus.FP_reg_write_unit, e.fw);
            chk("rd_used", bus.rd_used, e.rdu);
            chk("error_issue", bus.error_issue, e.err);
        end
    end
    initial begin
        model_reset();
        idle();
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0;
        // int rd x5 on divider; int rs1 hits, FP rs1 does not
        issue(0, 5, 1, 0); step();
        idle(); bus.dec_rs1 = 5; step();
        bus.dec_rs1_fp = 1; step();
        // FP unit 3 retiring in the same cycle is bypassed
        idle(); issue(3, 7, 0, 1); step();
        idle(); bus.dec_rs2 = 7; bus.dec_rs2_fp = 1; bus.unit_done[3] = 1; step();
        idle(); bus.dec_rs2 = 7; bus.dec_rs2_fp = 1; step();
        // kill unit 2 result, then let it finish
        idle(); issue(2, 4, 0, 1); step();
        idle(); bus.clear_rd[2] = 1; step();
        idle(); bus.dec_rd = 4; bus.dec_fp_write = 1; step();
        idle(); bus.clear_rd[2] = 1; bus.unit_done[2] = 1; step();
        idle(); step();
        // illegal issue to busy divider, then legal back-to-back issue with done
        bus.unit_done[0] = 1; step();
        idle(); issue(0, 9, 1, 0); step();
        idle(); issue(0, 12, 1, 0); step();
        idle(); bus.dec_rd = 9; bus.dec_reg_write = 1; step();
        idle(); issue(0, 12, 1, 0); bus.unit_done[0] = 1; step();
        idle(); bus.dec_rs1 = 12; step();
        // int x0 is occupancy only; rs3 only counts for R4
        idle(); bus.unit_done[0] = 1; step();
        idle(); issue(0, 0, 1, 0); step();
        idle(); issue(5, 6, 0, 1); step();
        idle(); bus.dec_rs3 = 6; step();
        bus.is_R4_instruction = 1; step();
        // async reset with several units busy
        idle(); bus.unit_done = '1; step();
        idle(); issue(1, 3, 1, 0); step();
        idle(); issue(4, 8, 0, 1); step();
        idle(); issue(6, 2, 1, 0); step();
        idle(); bus.dec_rs1 = 3; reset = 1'b1; step();
        step();
        reset = 1'b0; idle(); step(); step();
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 2) == 0) begin
                int t;
                t = $urandom_range(0, 3);
                issue($urandom_range(0, N - 1), $urandom_range(0, 7), t == 0 || t == 3, t == 1);
            end
            for (int i = 0; i < N; i++) begin
                bus.unit_done[i] = $urandom_range(0, 5) == 0;
                bus.clear_rd[i]  = $urandom_range(0, 9) == 0;
            end
            bus.dec_rs1 = W'($urandom_range(0, 7)); bus.dec_rs1_fp = 1'($urandom_range(0, 1));
            bus.dec_rs2 = W'($urandom_range(0, 7)); bus.dec_rs2_fp = 1'($urandom_range(0, 1));
            bus.dec_rs3 = W'($urandom_range(0, 7)); bus.is_R4_instruction = 1'($urandom_range(0, 1));
            bus.dec_rd = W'($urandom_range(0, 7));
            bus.dec_reg_write = 1'($urandom_range(0, 1)); bus.dec_fp_write = 1'($urandom_range(0, 1));
            reset = $urandom_range(0, 299) == 0;
            step();
        end
        reset = 1'b0; idle(); step();
        @(negedge clk); #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
